// File: rtl/memory_stage_ctrl.sv
// Y86-64 memory stage: one data-memory access per instruction over req/ack, bounds check, halt on exception.
// Optional MEM_ALIGN_CHECK_EN: misaligned addresses are reported as ADR instead of being issued.
module memory_stage_ctrl #(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic [3:0]  e_icode,
  input  logic [2:0]  e_stat,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [63:0] e_valP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_icode,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valE,
  output logic [63:0] m_valM
);

  localparam logic [2:0]  STAT_AOK  = 3'd1;
  localparam logic [2:0]  STAT_ADR  = 3'd3;
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, REQ, OUT, HALT} state_t;

  state_t      state_q;
  logic        req_q, we_q, valid_q;
  logic [63:0] addr_q, wdata_q, vale_q, valm_q;
  logic [3:0]  icode_q;
  logic [2:0]  stat_q;

  logic        acc_d, wr_d, oob_d;
  logic [63:0] addr_d, wdata_d;

  // Access decode of the incoming instruction.
  always_comb begin
    acc_d   = 1'b0;
    wr_d    = 1'b0;
    addr_d  = 64'd0;
    wdata_d = 64'd0;
    unique case (e_icode)
      4'h4: begin acc_d = 1'b1; wr_d = 1'b1; addr_d = e_valE; wdata_d = e_valA; end
      4'h5: begin acc_d = 1'b1;              addr_d = e_valE; end
      4'hA: begin acc_d = 1'b1; wr_d = 1'b1; addr_d = e_valE; wdata_d = e_valA; end
      4'hB: begin acc_d = 1'b1;              addr_d = e_valA; end
      4'h8: begin acc_d = 1'b1; wr_d = 1'b1; addr_d = e_valE; wdata_d = e_valP; end
      4'h9: begin acc_d = 1'b1;              addr_d = e_valA; end
      default: ;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    oob_d = (addr_d > LAST_ADDR) || (addr_d[2:0] != 3'd0);
`else
    oob_d = (addr_d > LAST_ADDR);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      valid_q <= 1'b0;
      icode_q <= 4'd0;
      stat_q  <= STAT_AOK;
      vale_q  <= 64'd0;
      valm_q  <= 64'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (e_valid) begin
            icode_q <= e_icode;
            vale_q  <= e_valE;
            valm_q  <= 64'd0;
            if (e_stat != STAT_AOK) begin
              stat_q  <= e_stat;
              valid_q <= 1'b1;
              state_q <= OUT;
            end else if (!acc_d || oob_d) begin
              stat_q  <= acc_d ? STAT_ADR : STAT_AOK;
              valid_q <= 1'b1;
              state_q <= OUT;
            end else begin
              stat_q  <= STAT_AOK;
              req_q   <= 1'b1;
              we_q    <= wr_d;
              addr_q  <= addr_d;
              wdata_q <= wdata_d;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (!we_q) valm_q <= mem_rdata;
            if (mem_err) stat_q <= STAT_ADR;
            valid_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            valid_q <= 1'b0;
            state_q <= (stat_q != STAT_AOK) ? HALT : IDLE;
          end
        end
        HALT: ;
        default: state_q <= HALT;
      endcase
    end
  end

  // e_ready depends on state only, so there is no path from m_ready back upstream.
  assign e_ready   = (state_q == IDLE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m_valid   = valid_q;
  assign m_icode   = icode_q;
  assign m_stat    = stat_q;
  assign m_valE    = vale_q;
  assign m_valM    = valm_q;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Randomized bench for memory_stage_ctrl against a transaction-level model of the access table and status rules.
module tb_memory_stage_ctrl;

  localparam int unsigned MEM_BYTES = 8192;
  localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

  logic        clk, rst_n;
  logic        e_valid, e_ready;
  logic [3:0]  e_icode;
  logic [2:0]  e_stat;
  logic [63:0] e_valE, e_valA, e_valP;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        m_valid, m_ready;
  logic [3:0]  m_icode;
  logic [2:0]  m_stat;
  logic [63:0] m_valE, m_valM;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .e_valid(e_valid), .e_ready(e_ready), .e_icode(e_icode), .e_stat(e_stat),
    .e_valE(e_valE), .e_valA(e_valA), .e_valP(e_valP),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_icode(m_icode), .m_stat(m_stat),
    .m_valE(m_valE), .m_valM(m_valM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".e_ready"}, 64'(e_ready), 64'd1);
    check_eq({tag, ".mem_req"}, 64'(mem_req), 64'd0);
    check_eq({tag, ".mem_we"}, 64'(mem_we), 64'd0);
    check_eq({tag, ".mem_addr"}, mem_addr, 64'd0);
    check_eq({tag, ".mem_wdata"}, mem_wdata, 64'd0);
    check_eq({tag, ".m_valid"}, 64'(m_valid), 64'd0);
    check_eq({tag, ".m_icode"}, 64'(m_icode), 64'd0);
    check_eq({tag, ".m_stat"}, 64'(m_stat), 64'd1);
    check_eq({tag, ".m_valE"}, m_valE, 64'd0);
    check_eq({tag, ".m_valM"}, m_valM, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  // Reference model: which access an instruction makes, per the access table.
  task automatic model_access(input logic [3:0] icode, input logic [63:0] va, input logic [63:0] ve,
                              input logic [63:0] vp, output bit acc, output bit wr,
                              output logic [63:0] addr, output logic [63:0] data);
    acc = 1; wr = 0; addr = ve; data = 64'd0;
    case (icode)
      4'h4, 4'hA: begin wr = 1; data = va; end
      4'h5: ;
      4'h8: begin wr = 1; data = vp; end
      4'hB, 4'h9: addr = va;
      default: acc = 0;
    endcase
  endtask

  function automatic bit model_oob(input logic [63:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return (addr > LAST) || (addr % 8 != 0);
`else
    return addr > LAST;
`endif
  endfunction

  // One full instruction; returns 1 if the stage is expected to halt afterwards.
  task automatic run_instr(input logic [3:0] icode, input logic [2:0] stat, input logic [63:0] ve,
                           input logic [63:0] va, input logic [63:0] vp, input int ack_wait,
                           input logic [63:0] rdata, input bit err, input int stall, output bit halted);
    bit acc, wr, issue;
    logic [63:0] addr, data, exp_valm;
    logic [2:0]  exp_stat;
    int n;
    model_access(icode, va, ve, vp, acc, wr, addr, data);
    issue    = (stat == 3'd1) && acc && !model_oob(addr);
    exp_stat = (stat != 3'd1) ? stat : (acc && !issue) ? 3'd3 : 3'd1;
    exp_valm = 64'd0;

    @(negedge clk);
    n = 0;
    while (!e_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("e_ready_idle", 64'(e_ready), 64'd1);
    e_valid = 1'b1; e_icode = icode; e_stat = stat; e_valE = ve; e_valA = va; e_valP = vp;
    @(negedge clk);
    e_valid = 1'b0; e_valE = $urandom; e_valA = $urandom;
    check_eq("e_ready_busy", 64'(e_ready), 64'd0);

    if (issue) begin
      check_eq("m_valid_in_req", 64'(m_valid), 64'd0);
      for (int i = 0; i <= ack_wait; i++) begin
        check_eq("mem_req", 64'(mem_req), 64'd1);
        check_eq("mem_we", 64'(mem_we), 64'(wr));
        check_eq("mem_addr", mem_addr, addr);
        if (wr) check_eq("mem_wdata", mem_wdata, data);
        if (i < ack_wait) @(negedge clk);
      end
      mem_ack = 1'b1; mem_rdata = rdata; mem_err = err;
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
      check_eq("mem_req_drop", 64'(mem_req), 64'd0);
      if (!wr) exp_valm = rdata;
      if (err) exp_stat = 3'd3;
    end else begin
      check_eq("no_mem_req", 64'(mem_req), 64'd0);
    end

    for (int i = 0; i <= stall; i++) begin
      check_eq("m_valid", 64'(m_valid), 64'd1);
      check_eq("m_icode", 64'(m_icode), 64'(icode));
      check_eq("m_stat", 64'(m_stat), 64'(exp_stat));
      check_eq("m_valE", m_valE, ve);
      check_eq("m_valM", m_valM, exp_valm);
      check_eq("e_ready_out", 64'(e_ready), 64'd0);
      if (i < stall) @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_eq("m_valid_drop", 64'(m_valid), 64'd0);
    halted = (exp_stat != 3'd1);
    if (halted) begin
      repeat (3) begin
        check_eq("halt_e_ready", 64'(e_ready), 64'd0);
        check_eq("halt_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
      end
      check_eq("halt_m_valid", 64'(m_valid), 64'd0);
    end
    $display("instr icode=%0h stat=%0d addr=0x%0h issue=%0d exp_stat=%0d valM=0x%0h", icode, stat, addr, issue, exp_stat, exp_valm);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 9))
      0: a = LAST;
      1: a = LAST + 64'd1;
      2: a = 64'(MEM_BYTES);
      3: a = 64'hFFFF_FFFF_FFFF_FFF8;
      4: a = 64'($urandom_range(0, MEM_BYTES - 1));
      default: a = 64'($urandom_range(0, MEM_BYTES / 8 - 1)) * 64'd8;
    endcase
    return a;
  endfunction

  initial begin
    bit h;
    logic [3:0] ic;
    logic [2:0] st;
    rst_n = 1'b0; e_valid = 1'b0; e_icode = '0; e_stat = '0; e_valE = '0; e_valA = '0; e_valP = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    run_instr(4'h6, 3'd1, 64'h2A, 64'h0, 64'h0, 0, 64'h0, 0, 0, h);
    run_instr(4'h4, 3'd1, 64'h100, 64'hDEAD, 64'h0, 3, 64'h0, 0, 0, h);
    run_instr(4'hB, 3'd1, 64'h0, 64'h1F8, 64'h0, 0, 64'h55, 0, 0, h);
    run_instr(4'h5, 3'd1, LAST, 64'h0, 64'h0, 1, 64'h1234, 0, 4, h);
    run_instr(4'h8, 3'd1, 64'h40, 64'h0, 64'h777, 2, 64'h0, 0, 1, h);
    run_instr(4'h4, 3'd1, 64'h104, 64'h99, 64'h0, 0, 64'h0, 0, 0, h);
    if (h) do_reset();
    run_instr(4'h5, 3'd1, 64'(MEM_BYTES), 64'h0, 64'h0, 0, 64'h0, 0, 0, h);
    if (h) do_reset();
    run_instr(4'h9, 3'd1, 64'h0, 64'h80, 64'h0, 1, 64'hABC, 1, 4, h);
    if (h) do_reset();

    // Reset while a request is outstanding, then a late ack that must be ignored.
    @(negedge clk);
    e_valid = 1'b1; e_icode = 4'h4; e_stat = 3'd1; e_valE = 64'h200; e_valA = 64'h11;
    @(negedge clk);
    e_valid = 1'b0;
    check_eq("midreq_mem_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreq_rst");
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 64'hBAD; mem_err = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_err = 1'b0;
    check_reset_outputs("late_ack");
    $display("instr reset mid-REQ with late ack");

    for (int k = 0; k < 150; k++) begin
      ic = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      run_instr(ic, st, rand_addr(), rand_addr(), {$urandom, $urandom}, $urandom_range(0, 3),
                {$urandom, $urandom}, ($urandom_range(0, 15) == 0), $urandom_range(0, 3), h);
      if (h) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
